// File: rtl/bus_responder.sv
// Memory-side responder for the 6502 multiplexed bus: demuxes address/rw, issues one req/ack per bus cycle.
// Define BUS_RESPONDER_SYNC_EN for a 2-flop input synchronizer (phi asynchronous to clk); default is 1 stage.
module bus_responder #(
  parameter logic [7:0] IDLE_DATA = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        phi,
  input  logic [7:0]  ab_mux,
  input  logic [7:0]  db_in,
  output logic [7:0]  db_out,
  output logic [7:0]  db_oe,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        late_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic       phi_s;
  logic       phi_s_d;
  logic [7:0] ab_s;
  logic [7:0] db_s;
  logic       fall;
  logic       rise;
  logic [1:0] state;
  logic [7:0] addr_lo;
  logic [7:0] addr_hi;
  logic [7:0] rdata_r;
  logic       rw_r;
  logic       drive_r;
  logic       rise_seen;

  // phi stages reset low so a release with phi low never fakes a falling edge
`ifdef BUS_RESPONDER_SYNC_EN
  logic       phi_p0;
  logic [7:0] ab_p0;
  logic [7:0] db_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phi_p0  <= 1'b0;
      phi_s   <= 1'b0;
      phi_s_d <= 1'b0;
    end else begin
      phi_p0  <= phi;
      phi_s   <= phi_p0;
      phi_s_d <= phi_s;
    end
  end

  always_ff @(posedge clk) begin
    ab_p0 <= ab_mux;
    db_p0 <= db_in;
    ab_s  <= ab_p0;
    db_s  <= db_p0;
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phi_s   <= 1'b0;
      phi_s_d <= 1'b0;
    end else begin
      phi_s   <= phi;
      phi_s_d <= phi_s;
    end
  end

  always_ff @(posedge clk) begin
    ab_s <= ab_mux;
    db_s <= db_in;
  end
`endif

  assign fall = phi_s_d & ~phi_s;
  assign rise = ~phi_s_d & phi_s;

  // bus-cycle state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_lo   <= 8'h00;
      addr_hi   <= 8'h00;
      mem_wdata <= 8'h00;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      rw_r      <= 1'b0;
      drive_r   <= 1'b0;
      rise_seen <= 1'b0;
      late_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (phi_s) begin
            addr_lo <= ab_s;
            rw_r    <= db_s[0];
          end
          if (fall) begin
            addr_hi   <= ab_s;
            mem_wdata <= db_s;
            mem_req   <= 1'b1;
            mem_we    <= rw_r;
            rise_seen <= 1'b0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (rise) begin
            late_err  <= 1'b1;
            rise_seen <= 1'b1;
          end
          if (mem_ack) begin
            mem_req <= 1'b0;
            // an ack after the address phase has restarted must not drive the pins
            if (rise_seen || rise) begin
              state <= IDLE;
            end else begin
              drive_r <= ~rw_r;
              state   <= HOLD;
            end
          end
        end
        HOLD: begin
          if (rise) begin
            drive_r <= 1'b0;
            addr_lo <= ab_s;
            rw_r    <= db_s[0];
            state   <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          drive_r <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == REQ && mem_ack && !mem_we) begin
      rdata_r <= mem_rdata;
    end
  end

  // db_oe gated on raw phi so the pins are released the moment the address phase starts
  assign db_oe    = {8{drive_r & ~phi}};
  assign db_out   = drive_r ? rdata_r : IDLE_DATA;
  assign mem_addr = {addr_hi, addr_lo};
  assign busy     = (state == REQ) || (state == HOLD);

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: reset, read, write, late ack, reset mid-request.
module tb_bus_responder;

`ifdef BUS_RESPONDER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        phi;
  logic [7:0]  ab_mux;
  logic [7:0]  db_in;
  logic [7:0]  db_out;
  logic [7:0]  db_oe;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic        late_err;

  int checks = 0;
  int errors = 0;

  bus_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .phi       (phi),
    .ab_mux    (ab_mux),
    .db_in     (db_in),
    .db_out    (db_out),
    .db_oe     (db_oe),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .late_err  (late_err)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input logic [7:0] lo, input logic rw, input int n);
    phi    = 1'b1;
    ab_mux = lo;
    db_in  = {7'b0, rw};
    step(n);
  endtask

  task automatic start_data(input logic [7:0] hi, input logic [7:0] wd);
    phi    = 1'b0;
    ab_mux = hi;
    db_in  = wd;
  endtask

  task automatic wait_req();
    int lat;
    lat = 0;
    while (!mem_req && lat < 12) begin
      step();
      lat++;
    end
    chk("req_latency", lat, LAT);
  endtask

  task automatic ack(input logic [7:0] rd);
    mem_ack   = 1'b1;
    mem_rdata = rd;
    step();
    mem_ack   = 1'b0;
    mem_rdata = $urandom_range(0, 255);
  endtask

  initial begin
    // reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      phi       = $urandom_range(0, 1);
      ab_mux    = $urandom_range(0, 255);
      db_in     = $urandom_range(0, 255);
      mem_rdata = $urandom_range(0, 255);
      mem_ack   = $urandom_range(0, 1);
      step();
    end
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_db_out", db_out, 8'hFF);
    chk("rst_db_oe", db_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_late_err", late_err, 0);
    phi = 1'b1; ab_mux = 8'h00; db_in = 8'h00; mem_ack = 1'b0;
    step();
    rst_n = 1'b1;
    step(2);
    chk("post_rst_req", mem_req, 0);

    // read of 0x1234 returning 0xA5
    addr_phase(8'h34, 1'b0, 4);
    chk("rd_busy_idle", busy, 0);
    start_data(8'h12, 8'h00);
    wait_req();
    chk("rd_addr", mem_addr, 16'h1234);
    chk("rd_we", mem_we, 0);
    chk("rd_busy", busy, 1);
    chk("rd_oe_pre", db_oe, 0);
    step();
    chk("rd_req_held", mem_req, 1);
    ack(8'hA5);
    chk("rd_req_drop", mem_req, 0);
    chk("rd_oe", db_oe, 8'hFF);
    chk("rd_data", db_out, 8'hA5);
    step(2);
    chk("rd_oe_hold", db_oe, 8'hFF);
    phi = 1'b1; ab_mux = 8'hEF; db_in = 8'h01;
    #1;
    chk("rd_oe_phi_rise", db_oe, 0);
    chk("rd_data_phi_rise", db_out, 8'hA5);
    step(LAT);
    chk("rd_busy_end", busy, 0);
    chk("rd_db_out_end", db_out, 8'hFF);
    chk("rd_late", late_err, 0);

    // write of 0x5A to 0xBEEF
    addr_phase(8'hEF, 1'b1, 3);
    start_data(8'hBE, 8'h5A);
    wait_req();
    chk("wr_addr", mem_addr, 16'hBEEF);
    chk("wr_we", mem_we, 1);
    chk("wr_wdata", mem_wdata, 8'h5A);
    chk("wr_oe_req", db_oe, 0);
    step();
    ack(8'h99);
    chk("wr_req_drop", mem_req, 0);
    chk("wr_oe_ack", db_oe, 0);
    chk("wr_busy_hold", busy, 1);
    step(2);
    chk("wr_oe_late", db_oe, 0);
    addr_phase(8'h78, 1'b0, LAT + 2);
    chk("wr_busy_end", busy, 0);

    // late ack: read of 0x5678, ack 3 cycles after phi rises
    start_data(8'h56, 8'h00);
    wait_req();
    chk("la_addr", mem_addr, 16'h5678);
    step(2);
    phi = 1'b1; ab_mux = 8'h9A; db_in = 8'h00;
    step(3);
    chk("la_err", late_err, 1);
    chk("la_req_held", mem_req, 1);
    chk("la_oe", db_oe, 0);
    ack(8'hC3);
    chk("la_req_drop", mem_req, 0);
    chk("la_busy", busy, 0);
    chk("la_db_out", db_out, 8'hFF);
    step(3);
    start_data(8'hBC, 8'h00);
    #1;
    chk("la_oe_data", db_oe, 0);
    wait_req();
    chk("la_next_addr", mem_addr, 16'hBC9A);
    step();
    ack(8'h3C);
    chk("la_next_oe", db_oe, 8'hFF);
    chk("la_next_data", db_out, 8'h3C);
    chk("la_err_sticky", late_err, 1);
    step(2);
    addr_phase(8'h11, 1'b0, LAT + 2);
    chk("la_next_busy", busy, 0);

    // reset asserted mid-request
    start_data(8'h22, 8'h00);
    wait_req();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_req", mem_req, 0);
    chk("mr_busy", busy, 0);
    chk("mr_addr", mem_addr, 0);
    chk("mr_late", late_err, 0);
    phi = 1'b1; ab_mux = 8'h44; db_in = 8'h01;
    step(2);
    rst_n = 1'b1;
    addr_phase(8'h44, 1'b1, 4);
    chk("mr_idle", mem_req, 0);
    start_data(8'h33, 8'h77);
    wait_req();
    chk("mr_next_addr", mem_addr, 16'h3344);
    chk("mr_next_we", mem_we, 1);
    chk("mr_next_wdata", mem_wdata, 8'h77);
    step();
    ack(8'h00);
    chk("mr_next_done", mem_req, 0);
    chk("mr_next_oe", db_oe, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
